// File: rtl/eth_rx_frame_buffer.sv
// Store-and-forward receive frame buffer.
// Forwards only CRC-good frames that fit completely in the buffer.
module eth_rx_frame_buffer #(
    parameter int DEPTH = 1024,
    parameter int CNT_W = 16
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic [31:0]      s_axis_tdata,
    input  logic             s_axis_tvalid,
    input  logic             s_axis_tlast,
    input  logic             s_axis_tuser,
    output logic             s_axis_tready,
    output logic [31:0]      m_axis_tdata,
    output logic             m_axis_tvalid,
    output logic             m_axis_tlast,
    input  logic             m_axis_tready,
    output logic [CNT_W-1:0] frames_ok,
    output logic [CNT_W-1:0] frames_dropped,
    output logic             overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] FULL_LVL = PW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        DROP
    } wr_state_t;

    wr_state_t state_q;
    wr_state_t state_d;

    logic [32:0]   mem [0:DEPTH-1];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] wr_commit;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] used;
    logic          full;

    logic we;
    logic do_commit;
    logic do_rewind;
    logic crc_drop;
    logic ovf_drop;

    logic [32:0] pre_data;
    logic        pre_vld;
    logic [32:0] out_q;
    logic        out_vld;
    logic        avail;
    logic        issue;
    logic        out_load;

    // The receiver FIFO cannot stall GMII, so input is never back-pressured.
    assign s_axis_tready = 1'b1;

    assign used = wr_ptr - rd_ptr;
    assign full = (used == FULL_LVL);

    // Write state register.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Write decisions: store, commit, or rewind to the last committed frame.
    always_comb begin
        state_d   = state_q;
        we        = 1'b0;
        do_commit = 1'b0;
        do_rewind = 1'b0;
        crc_drop  = 1'b0;
        ovf_drop  = 1'b0;
        if (s_axis_tvalid) begin
            unique case (state_q)
                DROP: begin
                    if (s_axis_tlast) begin
                        do_rewind = 1'b1;
                        ovf_drop  = 1'b1;
                        state_d   = IDLE;
                    end
                end
                default: begin
                    if (s_axis_tlast) begin
                        state_d = IDLE;
                        if (s_axis_tuser) begin
                            do_rewind = 1'b1;
                            crc_drop  = 1'b1;
                        end else if (full) begin
                            do_rewind = 1'b1;
                            ovf_drop  = 1'b1;
                        end else begin
                            we        = 1'b1;
                            do_commit = 1'b1;
                        end
                    end else if (full) begin
                        state_d = DROP;
                    end else begin
                        we      = 1'b1;
                        state_d = RECV;
                    end
                end
            endcase
        end
    end

    // Write and commit pointers.
    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr    <= '0;
            wr_commit <= '0;
        end else begin
            if (do_rewind) begin
                wr_ptr <= wr_commit;
            end else if (we) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_commit) begin
                wr_commit <= wr_ptr + PW'(1);
            end
        end
    end

    // Frame storage, {tlast, tdata} per entry.
    always_ff @(posedge aclk) begin
        if (we) begin
            mem[wr_ptr[AW-1:0]] <= {s_axis_tlast, s_axis_tdata};
        end
    end

    // Statistics with saturation, plus the overflow pulse.
    always_ff @(posedge aclk) begin
        if (areset) begin
            frames_ok      <= '0;
            frames_dropped <= '0;
            overflow       <= 1'b0;
        end else begin
            overflow <= ovf_drop;
            if (do_commit && (frames_ok != '1)) begin
                frames_ok <= frames_ok + CNT_W'(1);
            end
            if ((crc_drop || ovf_drop) && (frames_dropped != '1)) begin
                frames_dropped <= frames_dropped + CNT_W'(1);
            end
        end
    end

    // Read side: a registered memory read feeds a one-entry output register.
    assign avail    = (rd_ptr != wr_commit);
    assign out_load = pre_vld && (!out_vld || m_axis_tready);
    assign issue    = avail && (!pre_vld || out_load);

    // Synchronous memory read into the prefetch stage.
    always_ff @(posedge aclk) begin
        if (issue) begin
            pre_data <= mem[rd_ptr[AW-1:0]];
        end
    end

    // Read pointer, prefetch valid and output register.
    always_ff @(posedge aclk) begin
        if (areset) begin
            rd_ptr  <= '0;
            pre_vld <= 1'b0;
            out_vld <= 1'b0;
            out_q   <= '0;
        end else begin
            if (issue) begin
                rd_ptr  <= rd_ptr + PW'(1);
                pre_vld <= 1'b1;
            end else if (out_load) begin
                pre_vld <= 1'b0;
            end
            if (out_load) begin
                out_q   <= pre_data;
                out_vld <= 1'b1;
            end else if (m_axis_tready) begin
                out_vld <= 1'b0;
            end
        end
    end

    assign m_axis_tvalid = out_vld;
    assign m_axis_tdata  = out_q[31:0];
    assign m_axis_tlast  = out_q[32];

endmodule
